// File: rtl/l1_rr_arbiter.sv
// Round-robin grant controller for L1 interconnect host ports with burst lock and
// per-host outstanding-response caps. Optional per-host beat statistics: L1_ARB_STATS_EN.

// state      | meaning
// -----------+-------------------------------------------------------------
// ST_ARB     | rotate grants from ptr_q over eligible hosts
// ST_LOCKED  | only owner_q may be granted; timer_q counts cycles held
module l1_rr_arbiter #(
   parameter int NumHosts       = 2,
   parameter int MaxOutstanding = 4,
   parameter int LockTimeout    = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NumHosts-1:0]       host_req_valid_i,
   input  logic [NumHosts-1:0]       host_lock_i,
   input  logic [NumHosts-1:0]       network_ready_i,
   input  logic [NumHosts-1:0]       host_resp_valid_i,
`ifdef L1_ARB_STATS_EN
   input  logic                      stats_clr_i,
   output logic [NumHosts-1:0][15:0] grant_count_o,
`endif
   output logic [NumHosts-1:0]       host_grant_o,
   output logic                      lock_active_o,
   output logic                      lock_timeout_o,
   output logic [NumHosts-1:0]       outstanding_full_o
);

   localparam int IdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
   localparam int CntW = $clog2(MaxOutstanding + 1);
   localparam int TmrW = $clog2(LockTimeout + 1);

   typedef enum logic {ST_ARB, ST_LOCKED} state_t;

   state_t            state_q;
   logic [IdxW-1:0]   ptr_q;
   logic [IdxW-1:0]   owner_q;
   logic [TmrW-1:0]   timer_q;
   logic              timeout_q;
   logic [CntW-1:0]   cnt_q [NumHosts];
   logic [CntW-1:0]   cnt_d [NumHosts];
   logic [NumHosts-1:0] full_q;

   logic [NumHosts-1:0] eligible;
   logic [NumHosts-1:0] grant;
   logic [IdxW-1:0]     win;
   logic                win_lock;
   logic                owner_valid;
   logic                found;
   int                  tgt;

   function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] x);
      int t;
      t = int'(x) + 1;
      if (t >= NumHosts) t = 0;
      return IdxW'(t);
   endfunction

   assign eligible = host_req_valid_i & network_ready_i & ~full_q;

   always_comb begin
      grant       = '0;
      win         = '0;
      found       = 1'b0;
      tgt         = 0;
      owner_valid = 1'b0;
      for (int h = 0; h < NumHosts; h++)
         if (IdxW'(h) == owner_q) owner_valid = host_req_valid_i[h];
      if (state_q == ST_LOCKED) begin
         win = owner_q;
         for (int h = 0; h < NumHosts; h++)
            if (IdxW'(h) == owner_q) grant[h] = eligible[h];
      end else begin
         // Offset i from the pointer; the first eligible host wins.
         for (int i = 0; i < NumHosts; i++) begin
            tgt = int'(ptr_q) + i;
            if (tgt >= NumHosts) tgt = tgt - NumHosts;
            for (int h = 0; h < NumHosts; h++) begin
               if (!found && (h == tgt) && eligible[h]) begin
                  found    = 1'b1;
                  grant[h] = 1'b1;
                  win      = IdxW'(h);
               end
            end
         end
      end
   end

   assign win_lock = |(grant & host_lock_i);

   // Gated so the grant drops the moment reset asserts, even with requests held.
   assign host_grant_o       = grant & {NumHosts{rst_ni}};
   assign lock_active_o      = (state_q == ST_LOCKED);
   assign lock_timeout_o     = timeout_q;
   assign outstanding_full_o = full_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_ARB;
         ptr_q     <= '0;
         owner_q   <= '0;
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_ARB: begin
               if (|grant) begin
                  if (win_lock) begin
                     state_q <= ST_LOCKED;
                     owner_q <= win;
                     timer_q <= TmrW'(1);
                  end else begin
                     ptr_q <= next_idx(win);
                  end
               end
            end
            ST_LOCKED: begin
               timer_q <= timer_q + 1'b1;
               if (((|grant) && !win_lock) || !owner_valid ||
                   (timer_q == TmrW'(LockTimeout))) begin
                  state_q <= ST_ARB;
                  ptr_q   <= next_idx(owner_q);
                  timer_q <= '0;
               end else if (timer_q == TmrW'(LockTimeout - 1)) begin
                  // Registered one cycle early so the pulse lands in the release cycle.
                  timeout_q <= 1'b1;
               end
            end
            default: state_q <= ST_ARB;
         endcase
      end
   end

   always_comb begin
      for (int h = 0; h < NumHosts; h++) begin
         cnt_d[h] = cnt_q[h];
         if (grant[h] && !host_resp_valid_i[h])
            cnt_d[h] = cnt_q[h] + 1'b1;
         else if (!grant[h] && host_resp_valid_i[h] && (cnt_q[h] != '0))
            cnt_d[h] = cnt_q[h] - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int h = 0; h < NumHosts; h++) cnt_q[h] <= '0;
         full_q <= '0;
      end else begin
         for (int h = 0; h < NumHosts; h++) begin
            cnt_q[h]  <= cnt_d[h];
            full_q[h] <= (cnt_d[h] == CntW'(MaxOutstanding));
         end
      end
   end

`ifdef L1_ARB_STATS_EN
   logic [NumHosts-1:0][15:0] gcnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gcnt_q <= '0;
      end else begin
         for (int h = 0; h < NumHosts; h++) begin
            if (stats_clr_i)   gcnt_q[h] <= '0;
            else if (grant[h]) gcnt_q[h] <= gcnt_q[h] + 16'd1;
         end
      end
   end

   assign grant_count_o = gcnt_q;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert ($onehot0(host_grant_o))
            else $error("l1_rr_arbiter: grant not one-hot: %b", host_grant_o);
         for (int h = 0; h < NumHosts; h++)
            if (host_resp_valid_i[h] && !grant[h] && (cnt_q[h] == '0))
               $error("l1_rr_arbiter: response to host %0d with nothing outstanding", h);
      end
   end
`endif

endmodule

// File: doc/l1_rr_arbiter.md
Name: l1_rr_arbiter

Overview:
- Round-robin grant controller for host ports of the L1 variable-latency interconnect (core data port, Fraise accelerator host port, future hosts).
- Replaces the fixed-priority arbiter_l1.
- Adds fair rotation, per-host outstanding-response tracking with a cap, and a lock mode so a host can keep the bus for a multi-beat burst.
- Purely control: never touches address or data.

Parameters:
- NumHosts, 2, number of requesting hosts (2..8).
- MaxOutstanding, 4, accepted-but-unanswered requests allowed per host (1..15).
- LockTimeout, 16, max cycles a lock may hold the bus before forced release (>=2).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- host_req_valid_i  in  NumHosts  per-host request valid.
- host_lock_i  in  NumHosts  host requests to keep the grant after the current beat.
- network_ready_i  in  NumHosts  interconnect req_ready per host.
- host_resp_valid_i  in  NumHosts  interconnect resp_valid per host; the host always accepts.
- host_grant_o  out  NumHosts  one-hot-or-zero grant.
- lock_active_o  out  1  arbiter is in LOCKED state.
- lock_timeout_o  out  1  one-cycle pulse when a lock is force-released.
- outstanding_full_o  out  NumHosts  host has reached MaxOutstanding.

Behaviour:
- Reset values:
  - all outputs 0;
  - priority pointer = host 0;
  - outstanding counters 0;
  - state ARB;
  - lock timer 0.
- Eligibility: eligible[h] = host_req_valid_i[h] & network_ready_i[h] & ~outstanding_full_o[h].
- Grant is combinational from registered state plus current inputs (zero-cycle latency), as the core data_gnt_i requires.
- Accepted beat: host_grant_o[h] & host_req_valid_i[h] & network_ready_i[h]. Grant is asserted only when eligible, so every grant is an accepted beat.
- ARB state:
  - Grant the first eligible host searching pointer, pointer+1, … modulo NumHosts.
  - No eligible host -> grant 0, pointer unchanged.
  - On an accepted beat by host h with host_lock_i[h]=0: pointer <= (h+1) mod NumHosts.
  - With host_lock_i[h]=1: go to LOCKED, lock owner <= h, lock timer <= 1, pointer unchanged.
- LOCKED state:
  - Only the owner may be granted; grant = eligible[owner]; all other hosts see 0.
  - Lock timer increments every cycle.
  - Owner accepted beat with lock=0 -> ARB, pointer <= owner+1.
  - Owner deasserts host_req_valid_i -> ARB next cycle, pointer <= owner+1; abandoned lock is not an error.
  - Timer reaches LockTimeout -> ARB, pointer <= owner+1, lock_timeout_o pulses 1 cycle. A beat accepted in that same cycle still counts.
  - Owner full (outstanding cap) -> stays LOCKED; the timer keeps running.
- Outstanding counter per host, width $clog2(MaxOutstanding+1):
  - Accepted beat with host_we ignored: all beats are counted, and writes also receive resp_valid in this fabric.
  - +1 on accepted beat.
  - -1 on host_resp_valid_i.
  - Both in the same cycle -> unchanged.
  - outstanding_full_o[h] = (count == MaxOutstanding), registered from the counter.
  - resp_valid at count 0 -> saturate at 0. Under simulation, $error.
- Grant never asserts for more than one host: one-hot or zero every cycle.
- Asynchronous reset mid-lock or mid-burst returns to the reset values immediately; in-flight responses after reset are ignored, and counters saturate at 0.

Optional Feature:
- Macro: L1_ARB_STATS_EN.
- Defined:
  - adds output grant_count_o [NumHosts][15:0], a per-host accepted-beat counter that wraps at 16'hFFFF->0 and resets to 0;
  - adds input stats_clr_i (1), a synchronous clear that has priority over increment in the same cycle.
- Undefined: neither port exists, no counter logic is present, and behaviour is otherwise identical.

Test Plan:
1. Fairness: NumHosts=2, both hosts hold req_valid=1, ready=1, lock=0, responses returned 1 cycle later. Required: grants alternate H0,H1,H0,H1 starting with H0 after reset; never both asserted.
2. Outstanding cap: MaxOutstanding=4, H0 requests continuously, responses withheld. Required:
   - 4 grants, then outstanding_full_o[0]=1 and grant 0;
   - H1 is granted in the meantime;
   - one resp_valid[0] -> H0 granted again next cycle.
3. Lock burst: H0 asserts lock for beats 1-2, lock=0 on beat 3, while H1 requests throughout. Required:
   - H0 granted for 3 consecutive beats, lock_active_o=1 during beats 2-3;
   - H1 granted on the next cycle.
4. Lock timeout: LockTimeout=16, H0 holds lock and valid with network_ready_i[0]=0. Required: lock_timeout_o pulses on cycle 16, state returns to ARB, H1 granted on the following cycle.
5. Simultaneous events: H0 accepted beat and resp_valid[0] in the same cycle at count=2. Required: count stays 2. Reset asserted while LOCKED. Required: all outputs 0 asynchronously and the pointer restarts at H0.
6. With L1_ARB_STATS_EN: 70000 H1 beats. Required: grant_count_o[1] = 70000 mod 65536 = 4464; stats_clr_i pulsed together with a beat gives 0.
